// File: rtl/fpu_dispatch_pkg.sv
// fpu_dispatch_pkg: shared types, widths and exception codes for the FPU dispatch controller
// No ports; imported by fpu_dispatch_ctrl and fpu_rr_arbiter.
package fpu_dispatch_pkg;
   localparam int EXC_W  = 3;
   localparam int MODE_W = 3;
   localparam logic [EXC_W-1:0] EXC_NONE      = 3'd0;
   localparam logic [EXC_W-1:0] EXC_INEXACT   = 3'd1;
   localparam logic [EXC_W-1:0] EXC_UNDERFLOW = 3'd2;
   localparam logic [EXC_W-1:0] EXC_OVERFLOW  = 3'd3;
   localparam logic [EXC_W-1:0] EXC_DIVZERO   = 3'd4;
   localparam logic [EXC_W-1:0] EXC_INVALID   = 3'd5;
   typedef enum logic [0:0] {IN_IDLE = 1'b0, IN_WAIT_OP2 = 1'b1} in_state_t;
   typedef enum logic [1:0] {U_IDLE = 2'd0, U_RUN = 2'd1, U_DONE = 2'd2} unit_state_t;
   typedef enum logic [0:0] {O_IDLE = 1'b0, O_SEND = 1'b1} out_state_t;
   // Index width for n items, never below one bit.
   function automatic int sel_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin arbiter that owns its pointer register
// Ports: CLK, RSTn (sync, active-low); req_i[N] requests; advance_i lets the pointer
// move to the granted index; gnt_idx_o / gnt_vld_o first request at or after pointer+1.
module fpu_rr_arbiter
   import fpu_dispatch_pkg::*;
#(
   parameter int N = 2
) (
   input  logic                CLK,
   input  logic                RSTn,
   input  logic [N-1:0]        req_i,
   input  logic                advance_i,
   output logic [sel_w(N)-1:0] gnt_idx_o,
   output logic                gnt_vld_o
);
   localparam int W = sel_w(N);
   logic [W-1:0] ptr_q, ptr_d;
   // Scan from the farthest offset down so the nearest request after the pointer wins.
   always_comb begin
      gnt_idx_o = '0;
      gnt_vld_o = 1'b0;
      for (int k = N; k >= 1; k--) begin
         if (req_i[(int'(ptr_q) + k) % N]) begin
            gnt_idx_o = W'((int'(ptr_q) + k) % N);
            gnt_vld_o = 1'b1;
         end
      end
   end
   assign ptr_d = (advance_i && gnt_vld_o) ? gnt_idx_o : ptr_q;
   always_ff @(posedge CLK) ptr_q <= !RSTn ? '0 : ptr_d;
endmodule

// File: rtl/fpu_dispatch_ctrl.sv
// fpu_dispatch_ctrl: dispatches operand pairs to NUM_UNITS FPU units and returns results in OUT_W beats
// Host side : CS, DIN, DIV, OPT, MODE in; DACK, BUSY, DR, TOUT out; DOUT/DOV/DTAG/EXC out with DOA in.
// Unit side : U_OP1, U_OP2, U_VALID, U_MODE out; U_RESULT, U_RVALID, U_EXC in.
// Clock CLK, reset RSTn (synchronous, active-low).
// Option FPU_DISPATCH_TIMEOUT_EN: discard a pending op1 after TIMEOUT_CYC cycles without op2 (TOUT pulse).
module fpu_dispatch_ctrl
   import fpu_dispatch_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int OUT_W       = 16,
   parameter int NUM_UNITS   = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                          CLK,
   input  logic                          RSTn,
   input  logic                          CS,
   input  logic [DATA_W-1:0]             DIN,
   input  logic                          DIV,
   input  logic [sel_w(NUM_UNITS)-1:0]   OPT,
   input  logic [MODE_W-1:0]             MODE,
   output logic                          DACK,
   output logic [NUM_UNITS-1:0]          BUSY,
   output logic                          DR,
   output logic [OUT_W-1:0]              DOUT,
   output logic                          DOV,
   input  logic                          DOA,
   output logic [sel_w(NUM_UNITS)-1:0]   DTAG,
   output logic [EXC_W-1:0]              EXC,
   output logic                          TOUT,
   output logic [NUM_UNITS*DATA_W-1:0]   U_OP1,
   output logic [NUM_UNITS*DATA_W-1:0]   U_OP2,
   output logic [NUM_UNITS-1:0]          U_VALID,
   output logic [MODE_W-1:0]             U_MODE,
   input  logic [NUM_UNITS*DATA_W-1:0]   U_RESULT,
   input  logic [NUM_UNITS-1:0]          U_RVALID,
   input  logic [NUM_UNITS*EXC_W-1:0]    U_EXC
);
   localparam int SEL_W = sel_w(NUM_UNITS);
   localparam int BX    = 1 << SEL_W;
   localparam int BEATS = DATA_W / OUT_W;
   localparam int BW    = sel_w(BEATS);

   in_state_t                          in_q, in_d;
   out_state_t                         o_q, o_d;
   unit_state_t                        u_q [NUM_UNITS];
   unit_state_t                        u_d [NUM_UNITS];
   logic [SEL_W-1:0]                   tgt_q, tgt_d, sel_q, sel_d, gnt_idx;
   logic [BW-1:0]                      beat_q, beat_d;
   logic [NUM_UNITS-1:0][DATA_W-1:0]   op1_q, op2_q, res_q;
   logic [NUM_UNITS-1:0][EXC_W-1:0]    exc_q;
   logic [NUM_UNITS-1:0]               uvalid_q, cap, done;
   logic [BX-1:0]                      busy_ext;
   logic [DATA_W-1:0]                  sh;
   logic                               opt_ok, acc1, acc2, last, gnt_vld, dr_q;

   // Input side: op1 needs a valid, idle target; op2 goes to the latched target regardless of OPT.
   assign busy_ext = BX'(BUSY);
   assign opt_ok   = {1'b0, OPT} < (SEL_W+1)'(NUM_UNITS);
   assign acc1     = in_q == IN_IDLE && CS && DIV && opt_ok && !busy_ext[OPT];
   assign acc2     = in_q == IN_WAIT_OP2 && CS && DIV;
   assign DACK     = acc1 | acc2;

`ifdef FPU_DISPATCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // Expiry loses to an op2 arriving in the same cycle; CS low already discards on its own.
   assign TOUT  = in_q == IN_WAIT_OP2 && CS && !DIV && cnt_q == CW'(TIMEOUT_CYC - 1);
   assign cnt_d = acc1 ? '0 : cnt_q + 1'b1;
   always_ff @(posedge CLK) cnt_q <= !RSTn ? '0 : cnt_d;
`else
   assign TOUT = 1'b0;
`endif

   assign in_d  = acc1 ? IN_WAIT_OP2 :
                  (in_q == IN_WAIT_OP2 && (!CS || DIV || TOUT)) ? IN_IDLE : in_q;
   assign tgt_d = acc1 ? OPT : tgt_q;

   // Unit FSMs: issue, capture and release can hit different units in the same cycle.
   assign last = beat_q == BW'(BEATS - 1);
   always_comb begin
      for (int i = 0; i < NUM_UNITS; i++) begin
         cap[i]  = u_q[i] == U_RUN && U_RVALID[i];
         done[i] = u_q[i] == U_DONE;
         BUSY[i] = u_q[i] != U_IDLE;
         u_d[i]  = (u_q[i] == U_IDLE && acc2 && tgt_q == SEL_W'(i)) ? U_RUN :
                   cap[i] ? U_DONE :
                   (done[i] && DOV && sel_q == SEL_W'(i) && DOA && last) ? U_IDLE : u_q[i];
      end
   end

   fpu_rr_arbiter #(.N(NUM_UNITS)) u_arb (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .req_i     (done),
      .advance_i (!DOV),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   // Output side: grant only from O_IDLE, so a result never starts in the cycle after the last beat.
   assign DOV    = o_q == O_SEND;
   assign o_d    = DOV ? ((DOA && last) ? O_IDLE : O_SEND) : (gnt_vld ? O_SEND : O_IDLE);
   assign sel_d  = DOV ? sel_q : gnt_idx;
   assign beat_d = DOV ? (DOA ? beat_q + 1'b1 : beat_q) : '0;
   assign sh     = res_q[sel_q] << (OUT_W * int'(beat_q));
   assign DOUT   = DOV ? sh[DATA_W-1 -: OUT_W] : '0;
   assign DTAG   = DOV ? sel_q : '0;
   assign EXC    = DOV ? exc_q[sel_q] : '0;
   assign DR     = dr_q;
   assign U_OP1  = op1_q;
   assign U_OP2  = op2_q;
   assign U_VALID = uvalid_q;
   assign U_MODE = MODE;

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         in_q     <= IN_IDLE;
         o_q      <= O_IDLE;
         tgt_q    <= '0;
         sel_q    <= '0;
         beat_q   <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         res_q    <= '0;
         exc_q    <= '0;
         uvalid_q <= '0;
         dr_q     <= 1'b0;
         for (int i = 0; i < NUM_UNITS; i++) u_q[i] <= U_IDLE;
      end else begin
         in_q     <= in_d;
         o_q      <= o_d;
         tgt_q    <= tgt_d;
         sel_q    <= sel_d;
         beat_q   <= beat_d;
         uvalid_q <= acc2 ? NUM_UNITS'(1) << tgt_q : '0;
         dr_q     <= |cap;
         for (int i = 0; i < NUM_UNITS; i++) begin
            u_q[i] <= u_d[i];
            if (acc1 && OPT == SEL_W'(i)) op1_q[i] <= DIN;
            if (acc2 && tgt_q == SEL_W'(i)) op2_q[i] <= DIN;
            if (cap[i]) begin
               res_q[i] <= U_RESULT[i*DATA_W +: DATA_W];
               exc_q[i] <= U_EXC[i*EXC_W +: EXC_W];
            end
         end
      end
   end
endmodule

// File: tb/tb_fpu_dispatch_ctrl.sv
// tb_fpu_dispatch_ctrl: directed self-checking bench for fpu_dispatch_ctrl (3 units, 32-bit data, 16-bit beats)
module tb_fpu_dispatch_ctrl;
   logic        CLK = 1'b0, RSTn, CS, DIV, DOA;
   logic [31:0] DIN;
   logic [1:0]  OPT, DTAG;
   logic [2:0]  MODE, EXC, U_MODE, BUSY, U_VALID, U_RVALID;
   logic        DACK, DR, DOV, TOUT;
   logic [15:0] DOUT;
   logic [95:0] U_OP1, U_OP2, U_RESULT;
   logic [8:0]  U_EXC;
   int          n_asrt = 0, n_fail = 0;

   always #5 CLK = ~CLK;

   fpu_dispatch_ctrl #(.DATA_W(32), .OUT_W(16), .NUM_UNITS(3), .TIMEOUT_CYC(4)) dut (
      .CLK(CLK), .RSTn(RSTn), .CS(CS), .DIN(DIN), .DIV(DIV), .OPT(OPT), .MODE(MODE),
      .DACK(DACK), .BUSY(BUSY), .DR(DR), .DOUT(DOUT), .DOV(DOV), .DOA(DOA), .DTAG(DTAG),
      .EXC(EXC), .TOUT(TOUT), .U_OP1(U_OP1), .U_OP2(U_OP2), .U_VALID(U_VALID),
      .U_MODE(U_MODE), .U_RESULT(U_RESULT), .U_RVALID(U_RVALID), .U_EXC(U_EXC)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      RSTn = 1'b0; CS = 1'b0; DIV = 1'b0; DOA = 1'b0; DIN = '0; OPT = '0; MODE = 3'd2;
      U_RESULT = '0; U_RVALID = '0; U_EXC = '0;
      cyc(); cyc(); #1;
      chk("reset_ctl", {DACK, DR, DOV, TOUT, U_VALID, BUSY}, 0);
      chk("reset_dat", {DOUT, DTAG, EXC}, 0);
      chk("reset_ops", U_OP1 | U_OP2, 0);
      chk("umode", U_MODE, 3'd2);
      RSTn = 1'b1; CS = 1'b1;
      // single add on unit 0
      cyc(); DIV = 1'b1; OPT = 2'd0; DIN = 32'h3F80_0000; #1;
      chk("add_op1_dack", DACK, 1);
      cyc(); DIN = 32'h4000_0000; #1;
      chk("add_op2_dack", DACK, 1);
      chk("add_op1_reg", U_OP1[31:0], 32'h3F80_0000);
      cyc(); DIV = 1'b0; #1;
      chk("add_uvalid", U_VALID, 3'b001);
      chk("add_busy", BUSY, 3'b001);
      chk("add_op2_reg", U_OP2[31:0], 32'h4000_0000);
      cyc(); #1;
      chk("add_uvalid_end", U_VALID, 3'b000);
      cyc(); cyc(); cyc();
      U_RESULT[31:0] = 32'h4040_0000; U_EXC[2:0] = 3'd0; U_RVALID = 3'b001; #1;
      chk("add_dr_pre", DR, 0);
      cyc(); U_RVALID = '0; #1;
      chk("add_dr", {DR, DOV}, 2'b10);
      cyc(); #1;
      chk("add_beat0", {DR, DOV, DTAG, DOUT, EXC}, {1'b0, 1'b1, 2'd0, 16'h4040, 3'd0});
      DOA = 1'b1;
      cyc(); #1;
      chk("add_beat1", {DOV, DTAG, DOUT, BUSY}, {1'b1, 2'd0, 16'h0000, 3'b001});
      cyc(); DOA = 1'b0; #1;
      chk("add_release", {DOV, BUSY}, {1'b0, 3'b000});
      // contention: units 0 and 1 finish together, pointer 0 -> unit 1 first
      DIV = 1'b1; OPT = 2'd0; DIN = 32'hA; #1;
      chk("c_u0_op1", DACK, 1);
      cyc(); DIN = 32'hB; #1;
      chk("c_u0_op2", DACK, 1);
      cyc(); OPT = 2'd1; DIN = 32'hC; #1;
      chk("c_u1_op1", DACK, 1);
      cyc(); DIN = 32'hD; #1;
      chk("c_u1_op2", DACK, 1);
      cyc(); DIV = 1'b0; #1;
      chk("c_issue", {BUSY, U_VALID}, {3'b011, 3'b010});
      U_RESULT[31:0] = 32'h1111_2222; U_EXC[2:0] = 3'd1;
      U_RESULT[63:32] = 32'h3333_4444; U_EXC[5:3] = 3'd5;
      U_RVALID = 3'b011;
      cyc(); U_RVALID = '0; #1;
      chk("c_dr", {DR, DOV}, 2'b10);
      cyc(); DIV = 1'b1; OPT = 2'd3; DIN = 32'hDEAD; #1;
      chk("c_first_u1", {DOV, DTAG, DOUT, EXC}, {1'b1, 2'd1, 16'h3333, 3'd5});
      chk("invalid_opt_dack", DACK, 0);
      DOA = 1'b1;
      cyc(); DIV = 1'b0; #1;
      chk("c_u1_beat1", {DOV, DTAG, DOUT, BUSY}, {1'b1, 2'd1, 16'h4444, 3'b011});
      cyc(); DOA = 1'b0; #1;
      chk("c_gap", {DOV, BUSY}, {1'b0, 3'b001});
      cyc(); #1;
      chk("c_second_u0", {DOV, DTAG, DOUT, EXC}, {1'b1, 2'd0, 16'h1111, 3'd1});
      // backpressure while a new pair goes to idle unit 2
      for (int i = 0; i < 10; i++) begin
         DIV = (i < 2); OPT = 2'd2; DIN = (i == 0) ? 32'hE : 32'hF; #1;
         chk("bp_hold", {DOV, DTAG, DOUT, EXC}, {1'b1, 2'd0, 16'h1111, 3'd1});
         if (i < 2) chk("bp_dack", DACK, 1);
         if (i == 2) chk("bp_uvalid", {U_VALID, BUSY}, {3'b100, 3'b101});
         if (i == 3) chk("bp_uvalid_end", U_VALID, 3'b000);
         cyc();
      end
      DOA = 1'b1; #1;
      chk("bp_still", DOUT, 16'h1111);
      cyc(); #1;
      chk("bp_beat1", DOUT, 16'h2222);
      cyc(); DOA = 1'b0; #1;
      chk("bp_release", {DOV, BUSY, U_OP1[95:64], U_OP2[95:64]}, {1'b0, 3'b100, 32'hE, 32'hF});
      // busy reject on unit 2, same word to unit 0 accepted
      DIV = 1'b1; OPT = 2'd2; DIN = 32'h1234_5678; #1;
      chk("busy_reject", DACK, 0);
      OPT = 2'd0; #1;
      chk("busy_alt_accept", DACK, 1);
      cyc(); DIN = 32'h9ABC_DEF0; OPT = 2'd2; #1;
      chk("busy_op2", DACK, 1);
      cyc(); DIV = 1'b0; #1;
      chk("busy_state", {BUSY, U_VALID, U_OP1[31:0], U_OP2[31:0]},
          {3'b101, 3'b001, 32'h1234_5678, 32'h9ABC_DEF0});
      // unit 1 is idle so its pulse is ignored; unit 2 result is sent next
      U_RESULT[95:64] = 32'h5555_6666; U_EXC[8:6] = 3'd2; U_RESULT[63:32] = 32'h7777_8888;
      U_RVALID = 3'b110;
      cyc(); U_RVALID = '0; #1;
      chk("u2_dr", DR, 1);
      cyc(); #1;
      chk("u2_beat0", {DOV, DTAG, DOUT, EXC, BUSY}, {1'b1, 2'd2, 16'h5555, 3'd2, 3'b101});
      DOA = 1'b1;
      cyc(); #1;
      chk("u2_beat1", DOUT, 16'h6666);
      cyc(); DOA = 1'b0; #1;
      chk("u2_release", {DOV, BUSY}, {1'b0, 3'b001});
      cyc(); #1;
      chk("u1_ignored", {DOV, BUSY}, {1'b0, 3'b001});
      // reset mid-operation
      RSTn = 1'b0;
      cyc(); #1;
      chk("midrst", {BUSY, DOV, DR}, 0);
      chk("midrst_ops", U_OP1 | U_OP2, 0);
      RSTn = 1'b1;
      // op1 with no op2: timeout discards it when enabled, otherwise op2 still pairs
      DIV = 1'b1; OPT = 2'd1; DIN = 32'hAAAA_0001; #1;
      chk("to_op1", DACK, 1);
      cyc(); DIV = 1'b0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      for (int i = 1; i <= 4; i++) begin
         #1;
         chk("tout_pulse", TOUT, i == 4);
         cyc();
      end
      #1;
      chk("tout_end", TOUT, 0);
      DIV = 1'b1; OPT = 2'd3; #1;
      chk("to_next_is_op1_invalid", DACK, 0);
      OPT = 2'd1; DIN = 32'hAAAA_0002; #1;
      chk("to_next_is_op1", DACK, 1);
      cyc(); DIV = 1'b0; #1;
      chk("to_no_issue", {BUSY, U_VALID, U_OP1[63:32]}, {3'b000, 3'b000, 32'hAAAA_0002});
`else
      for (int i = 1; i <= 6; i++) begin
         #1;
         chk("no_tout", TOUT, 0);
         cyc();
      end
      DIV = 1'b1; OPT = 2'd3; DIN = 32'hAAAA_0002; #1;
      chk("wait_op2_dack", DACK, 1);
      cyc(); DIV = 1'b0; #1;
      chk("wait_op2_issue", {BUSY, U_VALID, U_OP2[63:32]}, {3'b010, 3'b010, 32'hAAAA_0002});
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_dispatch_ctrl.md
# fpu_dispatch_ctrl

Parametrised operand-dispatch and result-return controller for the FPU. It accepts two-word operand pairs from the host over a shared input bus and issues each pair to one of NUM_UNITS arithmetic units (adder, multiplier, …). It collects each unit's result and exception code and serialises results back to the host in OUT_W-bit beats under round-robin arbitration. It replaces the fixed two-unit top controller and sits between the host port and the per-unit control blocks.

## Interface
- DATA_W, 32: operand/result width; must be a multiple of OUT_W.
- OUT_W, 16: output beat width; BEATS = DATA_W/OUT_W (≥1).
- NUM_UNITS, 2: number of attached units, 1..8; SEL_W = max(1, clog2(NUM_UNITS)).
- TIMEOUT_CYC, 64: op2 wait limit in cycles; used only with the timeout macro.
- CLK  in  1  clock.
- RSTn  in  1  reset, synchronous, active-low.
- CS  in  1  chip select; qualifies DIV.
- DIN  in  DATA_W  operand word.
- DIV  in  1  DIN valid.
- OPT  in  SEL_W  target unit index; sampled with op1 only.
- MODE  in  3  rounding mode; broadcast to all units.
- DACK  out  1  word accepted this cycle (combinational).
- BUSY  out  NUM_UNITS  per-unit busy.
- DR  out  1  one-cycle pulse: a result was captured.
- DOUT  out  OUT_W  result beat.
- DOV  out  1  DOUT valid.
- DOA  in  1  host accepts the current beat.
- DTAG  out  SEL_W  unit index of the result on DOUT.
- EXC  out  3  exception code of the result on DOUT.
- TOUT  out  1  one-cycle pulse: op1 discarded by timeout.
- U_OP1, U_OP2  out  NUM_UNITS*DATA_W  per-unit operand registers.
- U_VALID  out  NUM_UNITS  one-cycle issue pulse per unit.
- U_MODE  out  3  equals MODE.
- U_RESULT  in  NUM_UNITS*DATA_W  unit results.
- U_RVALID  in  NUM_UNITS  result-valid pulse per unit.
- U_EXC  in  NUM_UNITS*3  unit exception codes.

## Operation
- Reset values: DACK, DR, DOV, TOUT, U_VALID and BUSY are 0; DOUT, DTAG, EXC, U_OP1 and U_OP2 are 0. All FSMs are in their idle state and the arbiter pointer is 0.
- Input FSM, IN_IDLE:
  - A word is accepted when CS&DIV, OPT<NUM_UNITS and BUSY[OPT]=0. On accept: DACK=1, DIN→U_OP1[OPT], OPT is latched as the target, next state IN_WAIT_OP2.
  - If OPT≥NUM_UNITS or the target is busy, the word is not accepted and DACK=0.
- Input FSM, IN_WAIT_OP2:
  - CS&DIV: DACK=1, DIN→U_OP2[target], BUSY[target] is set, U_VALID[target] pulses the next cycle, next state IN_IDLE. OPT is ignored in this state.
  - CS=0: op1 is discarded, next state IN_IDLE, no pulse.
- Unit FSM, one per unit: U_IDLE → U_RUN on issue → U_DONE on U_RVALID[i] (captures U_RESULT and U_EXC; DR pulses the next cycle) → U_IDLE when the last beat is acknowledged; BUSY[i] clears at that point.
- U_RVALID[i] outside U_RUN is ignored.
- Output FSM: O_IDLE → O_SEND → O_IDLE.
  - In O_IDLE, the round-robin arbiter grants the first U_DONE unit at or after pointer+1 (mod NUM_UNITS). The pointer is updated to the granted unit.
  - In O_SEND, DOV=1 and beats go MS-first: DOUT = result[DATA_W-1-k*OUT_W -: OUT_W] for beat k. DTAG and EXC are held for all beats.
  - Each beat is held until DOA; DOA advances to the next beat. DOA on the last beat returns to O_IDLE. DOA while DOV=0 is ignored.
- Simultaneous events:
  - An input accept, result capture in one unit and a beat acknowledge in another unit are all serviced in the same cycle.
  - Several units entering U_DONE in the same cycle are served in round-robin order.
- Reset mid-operation: all captured operands and results are dropped and the reset values apply on the next edge.

## Timing
- Op2 accepted at edge k → U_VALID[i] high in cycle k+1 for exactly 1 cycle.
- U_RVALID sampled at edge m → DR high in cycle m+1. Grant occurs at edge m+1 → first beat DOV in cycle m+2.
- Last DOA at edge n → BUSY[i] low in cycle n+1. The next grant is at edge n+1, so DOV is low for ≥1 cycle between results.
- Minimum back-to-back op1/op2 accepts: 1 word per cycle.

## Configuration
- FPU_DISPATCH_TIMEOUT_EN defined: a counter runs in IN_WAIT_OP2 from the op1 accept. If it reaches TIMEOUT_CYC with no op2 accepted, op1 is discarded, TOUT pulses for 1 cycle and the FSM returns to IN_IDLE. An op2 accepted in the same cycle as expiry wins.
- FPU_DISPATCH_TIMEOUT_EN undefined: no counter; IN_WAIT_OP2 waits indefinitely and TOUT is tied to 0.

## Structure
- Package fpu_dispatch_pkg holds:
  - Enums in_state_t, unit_state_t and out_state_t.
  - Constants EXC_W=3 and MODE_W=3.
  - Exception code localparams.
- Sub-module fpu_rr_arbiter is parametrised by N. Inputs: req[N], advance. Outputs: grant index, grant valid. It owns the pointer register.

## Test plan
- Single add, unit 0: op1=0x3F800000, op2=0x40000000, model returns 0x40400000 (EXC=0) after 5 cycles. Required: DACK on both words, U_VALID[0] 1 cycle, beats 0x4040 then 0x0000 with DTAG=0, BUSY[0] clears after the second DOA.
- Contention: units 0 and 1 issue U_RVALID in the same cycle with pointer=0. Required: unit 1 is sent first, then unit 0, with 1 idle cycle between.
- Busy reject: op1 to unit 1 while BUSY[1]=1 → DACK=0. The same word with OPT=0 → accepted.
- Invalid OPT=3 with NUM_UNITS=2 → no DACK; no state change.
- Backpressure: DOA held low for 10 cycles → DOUT, DTAG and EXC stable with DOV=1 throughout. A new op pair to an idle unit is accepted meanwhile.
- With FPU_DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=4: op1 is accepted, then no DIV → TOUT pulse at the 4th cycle. A following word is treated as op1.
